// File: rtl/pwm_multi.sv
// -----------------------------------------------------------------------------
// pwm_multi
//   N-channel PWM generator. All channels share one prescaler and one period
//   counter. Each channel has its own duty, phase offset and polarity. The
//   run-time settings are double-buffered. They are copied into shadow
//   registers only at a period boundary, so a period in progress never sees a
//   half-updated configuration.
//
// Ports
//   clk          system clock
//   resetb       asynchronous active-low reset
//   enable       1 = run; 0 = counters held at 0 and outputs at inactive level
//   prescale     clk divide minus 1 per counter step (0 = step every clk)
//   period       counter top value; a period lasts period+1 steps
//   duty         per-channel high steps, channel k at [k*CNT_W +: CNT_W]
//   phase        per-channel phase offset, same packing as duty
//   polarity     per-channel output inversion
//   update_req   1-clk pulse requesting a shadow load
//   update_ack   1-clk pulse: shadow registers were loaded
//   period_tick  1-clk pulse the clk after the counter wraps to 0
//   pwm_out      registered PWM outputs
//
// Update handshake
//   update_req is a single-clk pulse with no ready/back-pressure. It is
//   remembered in 'pending' until a load happens. Further requests while
//   pending are absorbed. When enabled, the load happens on the next counter
//   wrap. A request in the same clk as the wrap is consumed by that wrap. When
//   disabled, the load happens on the clk after the request. update_ack pulses
//   for exactly one clk, in the clk after the load. The inputs are sampled at
//   load time, not at request time.
// -----------------------------------------------------------------------------
module pwm_multi #(
   parameter int N_CH    = 4,
   parameter int CNT_W   = 8,
   parameter int PRESC_W = 8
) (
   input  logic                    clk,
   input  logic                    resetb,
   input  logic                    enable,
   input  logic [PRESC_W-1:0]      prescale,
   input  logic [CNT_W-1:0]        period,
   input  logic [N_CH*CNT_W-1:0]   duty,
   input  logic [N_CH*CNT_W-1:0]   phase,
   input  logic [N_CH-1:0]         polarity,
   input  logic                    update_req,
   output logic                    update_ack,
   output logic                    period_tick,
   output logic [N_CH-1:0]         pwm_out
);

   // Timebase state
   logic [PRESC_W-1:0]    presc_cnt;
   logic [CNT_W-1:0]      cnt;
   logic                  pending;

   // Shadow (active) configuration
   logic [CNT_W-1:0]      period_sh;
   logic [N_CH*CNT_W-1:0] duty_sh;
   logic [N_CH*CNT_W-1:0] phase_sh;
   logic [N_CH-1:0]       polarity_sh;

   logic                  step;
   logic                  wrap;
   logic                  load;
   logic [N_CH-1:0]       raw;

   // The prescale input is used live. If it drops below presc_cnt, the
   // compare misses and presc_cnt runs on through its natural 2^PRESC_W wrap
   // before it can match again.
   always_comb begin
      step = 1'b0;
      wrap = 1'b0;
      load = 1'b0;
      step = enable && (presc_cnt == prescale);
      wrap = step && (cnt == period_sh);
      if (enable) begin
         load = wrap && (pending || update_req);
      end else begin
         load = pending;
      end
   end

   // Per-channel compare. The phase-shifted position is formed one bit wider
   // than the counter. This lets cnt + phase exceed period_sh without
   // overflow before it is folded back into 0..period_sh. A phase outside
   // the period is ignored.
   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [CNT_W-1:0] duty_k;
      logic [CNT_W-1:0] phase_k;
      logic [CNT_W-1:0] phase_eff;
      logic [CNT_W:0]   sum_k;
      logic [CNT_W:0]   top_k;
      logic [CNT_W:0]   local_k;

      assign duty_k    = duty_sh[k*CNT_W +: CNT_W];
      assign phase_k   = phase_sh[k*CNT_W +: CNT_W];
      assign phase_eff = (phase_k > period_sh) ? '0 : phase_k;
      assign sum_k     = {1'b0, cnt} + {1'b0, phase_eff};
      assign top_k     = {1'b0, period_sh};
      assign local_k   = (sum_k > top_k) ? (sum_k - (top_k + {{CNT_W{1'b0}}, 1'b1}))
                                         : sum_k;
      // duty 0 is never satisfied. duty > period_sh is always satisfied.
      assign raw[k]    = (local_k < {1'b0, duty_k});
   end

   // Prescaler and period counter
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         presc_cnt <= '0;
         cnt       <= '0;
      end else if (!enable) begin
         presc_cnt <= '0;
         cnt       <= '0;
      end else if (step) begin
         presc_cnt <= '0;
         cnt       <= wrap ? '0 : cnt + 1'b1;
      end else begin
         presc_cnt <= presc_cnt + 1'b1;
      end
   end

   // Pending request, shadow load and the strobe outputs
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         pending     <= 1'b0;
         period_sh   <= '0;
         duty_sh     <= '0;
         phase_sh    <= '0;
         polarity_sh <= '0;
         update_ack  <= 1'b0;
         period_tick <= 1'b0;
      end else begin
         pending     <= load ? 1'b0 : (pending | update_req);
         update_ack  <= load;
         period_tick <= wrap;
         if (load) begin
            period_sh   <= period;
            duty_sh     <= duty;
            phase_sh    <= phase;
            polarity_sh <= polarity;
         end
      end
   end

   // Outputs are registered from the current cnt and the current shadows, so
   // they lag cnt by one clk. When disabled they sit at the inactive level.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         pwm_out <= '0;
      end else if (!enable) begin
         pwm_out <= polarity_sh;
      end else begin
         pwm_out <= raw ^ polarity_sh;
      end
   end

endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;

   localparam int N_CH    = 4;
   localparam int CNT_W   = 8;
   localparam int PRESC_W = 8;

   logic                  clk = 1'b0;
   logic                  resetb = 1'b0;
   logic                  enable = 1'b0;
   logic [PRESC_W-1:0]    prescale = '0;
   logic [CNT_W-1:0]      period = '0;
   logic [N_CH*CNT_W-1:0] duty = '0;
   logic [N_CH*CNT_W-1:0] phase = '0;
   logic [N_CH-1:0]       polarity = '0;
   logic                  update_req = 1'b0;
   logic                  update_ack;
   logic                  period_tick;
   logic [N_CH-1:0]       pwm_out;

   pwm_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
      .clk         (clk),
      .resetb      (resetb),
      .enable      (enable),
      .prescale    (prescale),
      .period      (period),
      .duty        (duty),
      .phase       (phase),
      .polarity    (polarity),
      .update_req  (update_req),
      .update_ack  (update_ack),
      .period_tick (period_tick),
      .pwm_out     (pwm_out)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- counters ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      else n_pass++;
   endtask

   // ---------------- reference model ----------------
   // Timebase is tracked as plain integers. Channel level is computed as
   // (cnt + phase) mod (period + 1) < duty.
   int m_presc, m_cnt;
   bit m_pend;
   int sh_period;
   int sh_duty[N_CH];
   int sh_phase[N_CH];
   bit sh_pol[N_CH];
   logic [5:0] exp_q[$];   // {tick, ack, pwm[3:0]}

   // Window statistics gathered from the DUT for the directed checks
   int hi_cnt[N_CH];
   int tick_cnt;
   int both01_cnt;

   task automatic model_reset();
      m_presc = 0; m_cnt = 0; m_pend = 0; sh_period = 0;
      for (int k = 0; k < N_CH; k++) begin
         sh_duty[k] = 0; sh_phase[k] = 0; sh_pol[k] = 0;
      end
      exp_q.delete();
   endtask

   function automatic bit ch_level(int k);
      int ph, pos;
      ph  = (sh_phase[k] > sh_period) ? 0 : sh_phase[k];
      pos = (m_cnt + ph) % (sh_period + 1);
      return bit'(pos < sh_duty[k]) ^ sh_pol[k];
   endfunction

   task automatic model_step();
      bit step, wrap, load;
      logic [N_CH-1:0] pw;
      step = enable && (m_presc == int'(prescale));
      wrap = step && (m_cnt == sh_period);
      load = enable ? (wrap && (m_pend || update_req)) : m_pend;
      for (int k = 0; k < N_CH; k++) pw[k] = enable ? ch_level(k) : sh_pol[k];
      exp_q.push_back({wrap, load, pw});
      if (!enable)     begin m_presc = 0; m_cnt = 0; end
      else if (step)   begin m_presc = 0; m_cnt = wrap ? 0 : m_cnt + 1; end
      else             m_presc = (m_presc + 1) % (1 << PRESC_W);
      m_pend = load ? 1'b0 : (m_pend || update_req);
      if (load) begin
         sh_period = int'(period);
         for (int k = 0; k < N_CH; k++) begin
            sh_duty[k]  = int'(duty[k*CNT_W +: CNT_W]);
            sh_phase[k] = int'(phase[k*CNT_W +: CNT_W]);
            sh_pol[k]   = polarity[k];
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at a negedge with inputs already applied. Returns at the next negedge.
   task automatic run_cycle();
      logic [5:0] e;
      model_step();
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("pwm_out", 32'(pwm_out), 32'(e[3:0]));
      check("period_tick", 32'(period_tick), 32'(e[5]));
      check("update_ack", 32'(update_ack), 32'(e[4]));
      for (int k = 0; k < N_CH; k++) hi_cnt[k] += int'(pwm_out[k]);
      tick_cnt   += int'(period_tick);
      both01_cnt += int'(pwm_out[0] & pwm_out[1]);
      @(negedge clk);
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   task automatic clear_window();
      for (int k = 0; k < N_CH; k++) hi_cnt[k] = 0;
      tick_cnt = 0;
      both01_cnt = 0;
   endtask

   task automatic set_ch(input int k, input int d, input int p);
      duty[k*CNT_W +: CNT_W]  = CNT_W'(d);
      phase[k*CNT_W +: CNT_W] = CNT_W'(p);
   endtask

   task automatic pulse_update();
      update_req = 1'b1;
      run_cycle();
      update_req = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int guard;
      model_reset();
      clear_window();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_pwm", 32'(pwm_out), 32'd0);
      check("rst_tick", 32'(period_tick), 32'd0);
      check("rst_ack", 32'(update_ack), 32'd0);
      resetb = 1'b1;
      model_reset();

      // Basic + phase + limits on the other channels
      enable = 1'b1; prescale = 8'd0; period = 8'd9; polarity = 4'b0000;
      set_ch(0, 3, 0); set_ch(1, 3, 5); set_ch(2, 0, 0); set_ch(3, 10, 0);
      pulse_update();
      run_n(20);
      clear_window(); run_n(10);
      check("basic_ch0_high", hi_cnt[0], 3);
      check("phase_ch1_high", hi_cnt[1], 3);
      check("phase_no_overlap", both01_cnt, 0);
      check("duty0_low", hi_cnt[2], 0);
      check("duty_over_high", hi_cnt[3], 10);
      check("basic_tick_per10", tick_cnt, 1);

      // Double-buffer: request at cnt=4 changes duty0 3->7 at the next wrap
      guard = 0;
      while (m_cnt != 4 && guard < 20) begin run_cycle(); guard++; end
      check("db_align_cnt4", m_cnt, 4);
      set_ch(0, 7, 0);
      pulse_update();
      guard = 0;
      while (!update_ack && guard < 20) begin run_cycle(); guard++; end
      check("db_ack_seen", 32'(update_ack), 32'd1);
      check("db_ack_with_tick", 32'(period_tick), 32'd1);
      run_n(5);
      clear_window(); run_n(10);
      check("db_ch0_high7", hi_cnt[0], 7);

      // Polarity inverts everything
      polarity = 4'b1111;
      pulse_update();
      run_n(20);
      clear_window(); run_n(10);
      check("pol_ch0", hi_cnt[0], 3);
      check("pol_ch1", hi_cnt[1], 7);
      check("pol_ch2", hi_cnt[2], 10);
      check("pol_ch3", hi_cnt[3], 0);

      // Disabled: outputs sit at polarity; update loads the clk after request
      enable = 1'b0;
      run_n(2);
      check("dis_out_pol", 32'(pwm_out), 32'hF);
      polarity = 4'b0101; set_ch(0, 3, 0); prescale = 8'd2;
      pulse_update();
      check("dis_ack_not_yet", 32'(update_ack), 32'd0);
      run_cycle();
      check("dis_ack", 32'(update_ack), 32'd1);
      run_cycle();
      check("dis_out_newpol", 32'(pwm_out), 32'h5);

      // Prescale 2: steps every 3 clks, tick every 30
      polarity = 4'b0000;
      pulse_update();
      run_n(2);
      enable = 1'b1;
      run_n(40);
      clear_window(); run_n(30);
      check("presc_tick_per30", tick_cnt, 1);
      check("presc_ch0_high9", hi_cnt[0], 9);

      // Reset in the middle of operation takes effect immediately
      #2 resetb = 1'b0;
      #1;
      check("midrst_pwm", 32'(pwm_out), 32'd0);
      check("midrst_tick", 32'(period_tick), 32'd0);
      check("midrst_ack", 32'(update_ack), 32'd0);
      @(negedge clk);
      resetb = 1'b1;
      model_reset();
      clear_window(); run_n(30);
      check("postrst_low", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            int p;
            p = int'($urandom_range(0, 15));
            period = CNT_W'(p);
            for (int k = 0; k < N_CH; k++)
               set_ch(k, int'($urandom_range(0, p + 2)), int'($urandom_range(0, p + 3)));
            polarity = N_CH'($urandom);
            update_req = 1'b1;
         end
         if ($urandom_range(0, 29) == 0) update_req = 1'b1;
         if ($urandom_range(0, 199) == 0) prescale = PRESC_W'($urandom_range(0, 3));
         if ($urandom_range(0, 149) == 0) enable = ~enable;
         run_cycle();
         update_req = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
